// File: rtl/ad_fmt_pkg.sv
// Shared constants, types and helpers for the UART voltage text-frame formatter.
package ad_fmt_pkg;

  localparam int              NUM_CH    = 2;
  localparam int              FRAME_LEN = 27;
  localparam int              IDX_W     = 5;
  localparam int              FLD_LEN   = 13;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [7:0] ASC_C     = 8'h43;
  localparam logic [7:0] ASC_H     = 8'h48;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_1     = 8'h31;
  localparam logic [7:0] ASC_2     = 8'h32;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_V     = 8'h56;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_QM    = 8'h3F;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } fmt_state_e;

  // Element [0] is channel 1, element [1] is channel 2.
  typedef struct packed {
    logic [NUM_CH-1:0][19:0] dec;
    logic [NUM_CH-1:0][7:0]  sig;
  } fmt_snap_t;

  function automatic logic [7:0] bcd2ascii(input logic [3:0] nib);
    return (nib > 4'd9) ? ASC_QM : (ASC_0 + {4'h0, nib});
  endfunction

  function automatic logic [7:0] sign2ascii(input logic [7:0] s);
    return (s == ASC_MINUS) ? ASC_MINUS : ASC_PLUS;
  endfunction

endpackage

// File: rtl/frame_byte_sel.sv
// Combinational map from byte index and snapshot to the ASCII byte of the frame.
module frame_byte_sel
  import ad_fmt_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  fmt_snap_t        snap,
  output logic [7:0]       tx_byte
);

  // Each channel owns a 13-byte field "CHn:sd.ddddV" plus a trailing separator.
  logic [NUM_CH-1:0][FLD_LEN-1:0][7:0] fld;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [7:0] tail;
    assign tail   = (g == NUM_CH - 1) ? ASC_CR : ASC_SP;
    assign fld[g] = {tail, ASC_V,
                     bcd2ascii(snap.dec[g][3:0]),   bcd2ascii(snap.dec[g][7:4]),
                     bcd2ascii(snap.dec[g][11:8]),  bcd2ascii(snap.dec[g][15:12]),
                     ASC_DOT, bcd2ascii(snap.dec[g][19:16]),
                     sign2ascii(snap.sig[g]), ASC_COLON,
                     8'(ASC_1 + 8'(g)), ASC_H, ASC_C};
  end

  logic       ch;
  logic [3:0] pos;

  always_comb begin
    ch      = (idx >= IDX_W'(FLD_LEN));
    pos     = 4'(ch ? (idx - IDX_W'(FLD_LEN)) : idx);
    tx_byte = (idx >= LAST_IDX) ? ASC_LF : fld[ch][pos];
  end

endmodule

// File: rtl/ad_uart_frame_fmt.sv
// Periodic two-channel voltage text framer feeding a UART TX over valid/ready.
module ad_uart_frame_fmt
  import ad_fmt_pkg::*;
#(
  parameter int FRAME_PERIOD = 5_000_000
) (
  input  logic        clk50m,
  input  logic        reset,
  input  logic [19:0] ch1_dec,
  input  logic [19:0] ch2_dec,
  input  logic [7:0]  ch1_sig,
  input  logic [7:0]  ch2_sig,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  drop_cnt
);

  localparam int CNT_W = $clog2(FRAME_PERIOD);

  logic [CNT_W-1:0] prd_cnt;
  logic             tick;
  fmt_state_e       state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  fmt_snap_t        snap, snap_d, in_snap;
  logic             valid_d, done_d;
  logic [7:0]       sel_byte;

  assign tick        = (prd_cnt == CNT_W'(FRAME_PERIOD - 1));
  assign in_snap.dec = {ch2_dec, ch1_dec};
  assign in_snap.sig = {ch2_sig, ch1_sig};

  always_comb begin
    state_d = state;
    idx_d   = idx;
    snap_d  = snap;
    valid_d = tx_valid;
    done_d  = 1'b0;
    case (state)
      ST_IDLE: if (tick) begin
        snap_d  = in_snap;
        idx_d   = '0;
        state_d = ST_SEND;
        valid_d = 1'b1;
      end
      ST_SEND: if (tx_valid && tx_ready) begin
        if (idx == LAST_IDX) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx + 1'b1;
        end
      end
    endcase
  end

  // Selector looks at next-state index/snapshot so tx_data can be registered.
  frame_byte_sel u_sel (
    .idx     (idx_d),
    .snap    (snap_d),
    .tx_byte (sel_byte)
  );

  always_ff @(posedge clk50m) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      snap       <= '0;
      prd_cnt    <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= 8'h00;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      snap       <= snap_d;
      prd_cnt    <= tick ? '0 : prd_cnt + 1'b1;
      tx_valid   <= valid_d;
      tx_data    <= valid_d ? sel_byte : 8'h00;
      busy       <= (state_d == ST_SEND);
      frame_done <= done_d;
      if (tick && (state == ST_SEND) && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
